// File: rtl/gate_arb_pkg.sv
//------------------------------------------------------------------------------
// Package : gate_arb_pkg
// Opcode values and FSM state encoding shared by the gate-unit arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gate_arb_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gate_unit_logic.sv
//------------------------------------------------------------------------------
// Module  : gate_unit_logic
// Combinational 2-input bitwise logic unit built from per-bit nand gates.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_unit_logic
    import gate_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    wire [WIDTH-1:0] w_na;
    wire [WIDTH-1:0] w_nb;
    wire [WIDTH-1:0] w_nab;
    wire [WIDTH-1:0] w_and;
    wire [WIDTH-1:0] w_or;
    wire [WIDTH-1:0] w_nor;
    wire [WIDTH-1:0] w_xa;
    wire [WIDTH-1:0] w_xb;
    wire [WIDTH-1:0] w_xor;
    wire [WIDTH-1:0] w_xnor;

    // Every function is derived from nand gates; xor uses the classic 4-nand form.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nand u_na   (w_na[i],   a_i[i],    a_i[i]);
        nand u_nb   (w_nb[i],   b_i[i],    b_i[i]);
        nand u_nab  (w_nab[i],  a_i[i],    b_i[i]);
        nand u_and  (w_and[i],  w_nab[i],  w_nab[i]);
        nand u_or   (w_or[i],   w_na[i],   w_nb[i]);
        nand u_nor  (w_nor[i],  w_or[i],   w_or[i]);
        nand u_xa   (w_xa[i],   a_i[i],    w_nab[i]);
        nand u_xb   (w_xb[i],   b_i[i],    w_nab[i]);
        nand u_xor  (w_xor[i],  w_xa[i],   w_xb[i]);
        nand u_xnor (w_xnor[i], w_xor[i],  w_xor[i]);
    end

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_NOT:  y_o = w_na;
            OP_AND:  y_o = w_and;
            OP_OR:   y_o = w_or;
            OP_NOR:  y_o = w_nor;
            OP_XOR:  y_o = w_xor;
            OP_XNOR: y_o = w_xnor;
            OP_NAND: y_o = w_nab;
            default: y_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gate_unit_arbiter.sv
//------------------------------------------------------------------------------
// Module  : gate_unit_arbiter
// Round-robin sharing of one registered bitwise logic unit among NUM_REQ ports.
// Optional macro GATE_ARB_ERR_EN adds resp_err flagging the reserved opcode.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_unit_arbiter
    import gate_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [3*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [WIDTH-1:0]           resp_data
`ifdef GATE_ARB_ERR_EN
    ,
    output logic                       resp_err
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             resp_valid_q;
    logic [IDW-1:0]   resp_id_q;
    logic [WIDTH-1:0] resp_data_q;
    logic [WIDTH-1:0] w_y;
    logic             w_gnt_found;
    logic [IDW-1:0]   w_gnt_idx;
    logic [IDW-1:0]   w_gnt_next;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_cand;

    // Scan requesters starting at the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum  = {1'b0, ptr_q} + (IDW+1)'(k);
            w_cand = (int'(w_sum) >= NUM_REQ) ? IDW'(int'(w_sum) - NUM_REQ) : IDW'(w_sum);
            if (!w_gnt_found && req_valid[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    assign w_gnt_next = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_gnt_found) begin
                    req_ready[w_gnt_idx] = 1'b1;
                    ptr_d                = w_gnt_next;
                    state_d              = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_valid_q && resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    gate_unit_logic #(
        .WIDTH (WIDTH)
    ) u_logic (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q         <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && w_gnt_found) begin
                id_q <= w_gnt_idx;
                op_q <= req_op[int'(w_gnt_idx)*3 +: 3];
                a_q  <= req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
                b_q  <= req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
            end
            if (state_q == ST_EXEC) begin
                resp_data_q  <= w_y;
                resp_id_q    <= id_q;
                resp_valid_q <= 1'b1;
            end
            if (state_q == ST_RESP && resp_valid_q && resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

`ifdef GATE_ARB_ERR_EN
    logic resp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            resp_err_q <= (op_q == OP_RSVD);
        end else if (state_q == ST_RESP && resp_valid_q && resp_ready) begin
            resp_err_q <= 1'b0;
        end
    end

    assign resp_err = resp_err_q;
`endif

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;

endmodule

`default_nettype wire
